owl_dma_read: RTL and testbench

- Single-plane frame-read DMA, programmed over the CPB register bus.
- Fetches a WIDTH×HEIGHT frame of PW-bit pixels from memory using fixed-length read bursts, buffers the returned DW-bit words, and unpacks them into a valid/ready pixel stream with sof/eof markers.
- Sits upstream of pixel-processing stages. Its memory image is the byte-per-pixel layout the write DMA produces: byte 0 of each word is the first pixel.

---
 rtl/owl_dma_read.sv | 246 ++++++++++++++++++++++++
 tb/tb_owl_dma_read.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/owl_dma_read.sv
// Frame-read DMA: fetches a WIDTH x HEIGHT frame in fixed-length bursts,
// buffers returned words in a FIFO and unpacks them LSB-first into a
// valid/ready pixel stream carrying sof/eof markers.
module owl_dma_read #(
  parameter int          WIDTH  = 1280,
  parameter int          HEIGHT = 960,
  parameter int          PW     = 8,
  parameter int          AW     = 32,
  parameter int          DW     = 64,
  parameter int          DMA_BL = 3,
  parameter int          BL     = 4,
  parameter int          APB_AW = 5,
  parameter int          FD     = 32,
  parameter logic [31:0] ID     = 32'hCE7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpb_w,
  input  logic [APB_AW-1:0] cpb_a,
  input  logic [31:0]       cpb_d,
  output logic [31:0]       cpb_q,
  output logic              irq,
  input  logic              bus_rrdy,
  output logic              bus_rval,
  output logic [BL-1:0]     bus_rlen,
  output logic [AW-1:0]     bus_raddr,
  input  logic              bus_dval,
  input  logic [DW-1:0]     bus_rdata,
  input  logic              dst_rdy,
  output logic              dst_val,
  output logic              dst_sof,
  output logic              dst_eof,
  output logic [PW-1:0]     dst_d
);

  localparam int BEATS = 1 << DMA_BL;
  localparam int PPW   = DW / PW;
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int NW    = NPIX * PW / DW;
  localparam int NB    = NW >> DMA_BL;
  localparam int BCW   = $clog2(NB + 1);
  localparam int PCW   = $clog2(NPIX);
  localparam int OW    = $clog2(FD + BEATS + 1);
  localparam int FAW   = $clog2(FD);
  localparam int XW    = $clog2(PPW);

  localparam logic [AW-1:0] BURST_BYTES = AW'(BEATS * DW / 8);

  localparam logic [APB_AW-1:0] A_IDR = APB_AW'(0);
  localparam logic [APB_AW-1:0] A_CR  = APB_AW'(1);
  localparam logic [APB_AW-1:0] A_SR  = APB_AW'(2);
  localparam logic [APB_AW-1:0] A_SA  = APB_AW'(3);
  localparam logic [APB_AW-1:0] A_LR  = APB_AW'(4);

  // Geometry must divide exactly into words and bursts; FIFO must hold two bursts.
  if ((NPIX * PW) % DW != 0 || NW % BEATS != 0 || NB < 1) begin : g_geom_chk
    $error("owl_dma_read: frame size does not divide into whole bursts");
  end
  if (FD < 2 * BEATS || (FD & (FD - 1)) != 0) begin : g_fd_chk
    $error("owl_dma_read: FD must be a power of 2 and at least two bursts");
  end
  if (PPW < 2 || DW % PW != 0) begin : g_ppw_chk
    $error("owl_dma_read: DW must hold at least two whole pixels");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic             busy;
  logic             done;
  logic             cr_ie;
  logic [31:0]      sa;
  logic [BCW-1:0]   bcnt;
  logic [OW-1:0]    outst;
  logic [OW-1:0]    outst_nxt;

  logic [DW-1:0]    mem [FD];
  logic [FAW:0]     wp;
  logic [FAW:0]     rp;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  logic [DW-1:0]    word_p0;
  logic [XW-1:0]    idx;
  logic [PCW-1:0]   pcnt;

  logic             launch;
  logic             acc;
  logic             hs;
  logic             last_in_word;
  logic             last_hs;
  logic             wr_sr_clr;

  assign launch    = cpb_w && (cpb_a == A_LR) && cpb_d[0] && (state == IDLE);
  assign wr_sr_clr = cpb_w && (cpb_a == A_SR) && cpb_d[0];
  assign acc       = bus_rval && bus_rrdy;
  assign hs        = dst_val && dst_rdy;
  assign last_hs   = hs && dst_eof;

  assign last_in_word = (idx == XW'(PPW - 1));
  assign push         = bus_dval && busy;
  assign pop          = busy && !fifo_empty && (!dst_val || (hs && last_in_word));

  assign fifo_empty = (wp == rp);
  assign fifo_full  = (wp[FAW] != rp[FAW]) && (wp[FAW-1:0] == rp[FAW-1:0]);

  assign dst_d   = word_p0[int'(idx) * PW +: PW];
  assign dst_sof = dst_val && (pcnt == '0);
  assign dst_eof = dst_val && (pcnt == PCW'(NPIX - 1));
  assign irq     = done && cr_ie;

  // Register read mux, combinational from the address.
  always_comb begin
    cpb_q = 32'd0;
    case (cpb_a)
      A_IDR:   cpb_q = ID;
      A_CR:    cpb_q = {31'd0, cr_ie};
      A_SR:    cpb_q = {30'd0, busy, done};
      A_SA:    cpb_q = sa;
      default: cpb_q = 32'd0;
    endcase
  end

  // Control and address registers written over CPB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_ie <= 1'b0;
      sa    <= 32'd0;
    end else if (cpb_w) begin
      if (cpb_a == A_CR) cr_ie <= cpb_d[0];
      if (cpb_a == A_SA) sa    <= cpb_d;
    end
  end

  // Words requested but not yet popped, projected to the end of this cycle.
  always_comb begin
    outst_nxt = outst;
    if (acc) outst_nxt = outst_nxt + OW'(BEATS);
    if (pop) outst_nxt = outst_nxt - OW'(1);
  end

  // Outstanding-word counter gating new requests against FIFO space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      outst <= '0;
    else if (launch) outst <= '0;
    else             outst <= outst_nxt;
  end

  // Transfer FSM: issues bursts, then waits for the last pixel to leave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcnt      <= '0;
      bus_rval  <= 1'b0;
      bus_rlen  <= '0;
      bus_raddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state     <= REQ;
            busy      <= 1'b1;
            bcnt      <= '0;
            bus_raddr <= AW'(sa);
            bus_rlen  <= BL'(BEATS - 1);
            bus_rval  <= 1'b1;
          end
        end
        REQ: begin
          if (acc) begin
            bcnt      <= bcnt + BCW'(1);
            bus_raddr <= bus_raddr + BURST_BYTES;
          end
          if (acc && (bcnt == BCW'(NB - 1))) begin
            state    <= DRAIN;
            bus_rval <= 1'b0;
          end else if (!bus_rval || acc) begin
            // A pending request is held until accepted; a new one starts only with room for a full burst.
            bus_rval <= (outst_nxt + OW'(BEATS)) <= OW'(FD);
          end
        end
        DRAIN: begin
          if (last_hs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // Completion beats a simultaneous software clear.
      if (state == DRAIN && last_hs) done <= 1'b1;
      else if (wr_sr_clr)            done <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wp[FAW-1:0]] <= bus_rdata;
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (FAW+1)'(1);
      if (pop)  rp <= rp + (FAW+1)'(1);
    end
  end

  // ---- stage p0: word held in the unpacker, pixels emitted LSB first ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_p0 <= '0;
      idx     <= '0;
      dst_val <= 1'b0;
      pcnt    <= '0;
    end else begin
      if (pop) begin
        word_p0 <= mem[rp[FAW-1:0]];
        idx     <= '0;
        dst_val <= 1'b1;
      end else if (hs && last_in_word) begin
        dst_val <= 1'b0;
      end else if (hs) begin
        idx <= idx + XW'(1);
      end
      if (launch)  pcnt <= '0;
      else if (hs) pcnt <= pcnt + PCW'(1);
    end
  end

  // Request pacing guarantees room for every returned beat.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop))
    else $error("owl_dma_read: read-data FIFO overflow");

endmodule

// File: tb/tb_owl_dma_read.sv
// Directed bench for owl_dma_read on a 32x4 frame with a byte-addressed
// memory model (byte at address n holds n[7:0]).
module tb_owl_dma_read;

  localparam int FD = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpb_w;
  logic [4:0]  cpb_a;
  logic [31:0] cpb_d;
  logic [31:0] cpb_q;
  logic        irq;
  logic        bus_rrdy;
  logic        bus_rval;
  logic [3:0]  bus_rlen;
  logic [31:0] bus_raddr;
  logic        bus_dval = 1'b0;
  logic [63:0] bus_rdata = '0;
  logic        dst_rdy = 1'b1;
  logic        dst_val;
  logic        dst_sof;
  logic        dst_eof;
  logic [7:0]  dst_d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor state (written only by the monitor process)
  int req_n = 0, pix_n = 0;
  int req_bad = 0, pix_bad = 0, mark_bad = 0, stab_bad = 0, hold_bad = 0, out_bad = 0;
  logic        stall_prev = 0, hold_prev = 0;
  logic [31:0] hold_addr = '0;
  logic [7:0]  sd = '0;
  logic        ss = 0, se = 0;

  // Frame bases and backpressure enable (written only by the main process)
  int freq0 = 0, fpix0 = 0;
  bit bp_en = 0;

  typedef struct {
    logic [31:0] a;
    int          t;
  } beat_t;
  beat_t bq[$];

  owl_dma_read #(.WIDTH(32), .HEIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpb_w(cpb_w), .cpb_a(cpb_a), .cpb_d(cpb_d), .cpb_q(cpb_q),
    .irq(irq),
    .bus_rrdy(bus_rrdy), .bus_rval(bus_rval), .bus_rlen(bus_rlen), .bus_raddr(bus_raddr),
    .bus_dval(bus_dval), .bus_rdata(bus_rdata),
    .dst_rdy(dst_rdy), .dst_val(dst_val), .dst_sof(dst_sof), .dst_eof(dst_eof), .dst_d(dst_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_word(input logic [31:0] a);
    logic [63:0] w;
    logic [31:0] b;
    for (int k = 0; k < 8; k++) begin
      b = a + 32'(k);
      w[k*8 +: 8] = b[7:0];
    end
    return w;
  endfunction

  // Memory: queue 8 beats per accepted request, first beat two cycles later
  always @(negedge clk) begin
    if (!rst_n) bq.delete();
    else if (bus_rval && bus_rrdy)
      for (int i = 0; i < 8; i++) bq.push_back('{bus_raddr + 32'(i * 8), cyc + 2 + i});
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n && bq.size() > 0 && bq[0].t <= cyc) begin
      bus_rdata = mk_word(bq[0].a);
      bus_dval  = 1'b1;
      void'(bq.pop_front());
    end else begin
      bus_dval = 1'b0;
    end
  end

  // Downstream ready: always 1, or ~30% low under backpressure
  always @(posedge clk) begin
    #1;
    dst_rdy = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Monitor: requests, pixels, hold/stability rules, outstanding bound
  always @(negedge clk) begin
    int rq, px;
    if (!rst_n) begin
      stall_prev = 0;
      hold_prev  = 0;
    end else begin
      rq = req_n - freq0;
      px = pix_n - fpix0;
      if (bus_rval && ((rq + 1) * 8 - px / 8 - 1 > FD)) out_bad++;
      if (hold_prev && (!bus_rval || bus_raddr != hold_addr)) hold_bad++;
      hold_prev = bus_rval && !bus_rrdy;
      hold_addr = bus_raddr;
      if (bus_rval && bus_rrdy) begin
        if (bus_raddr != 32'h1000 + 32'(rq * 64) || bus_rlen != 4'd7) req_bad++;
        req_n++;
      end
      if (stall_prev && (!dst_val || dst_d != sd || dst_sof != ss || dst_eof != se)) stab_bad++;
      stall_prev = dst_val && !dst_rdy;
      sd = dst_d;
      ss = dst_sof;
      se = dst_eof;
      if (dst_val && dst_rdy) begin
        if (dst_d != 8'(px)) pix_bad++;
        if (dst_sof != (px == 0) || dst_eof != (px == 127)) mark_bad++;
        pix_n++;
      end
    end
  end

  task automatic cpb_wr(input logic [4:0] a, input logic [31:0] d);
    cpb_w = 1'b1;
    cpb_a = a;
    cpb_d = d;
    @(posedge clk);
    #1;
    cpb_w = 1'b0;
  endtask

  task automatic cpb_rd(input logic [4:0] a, output logic [31:0] q);
    cpb_a = a;
    #1;
    q = cpb_q;
  endtask

  task automatic frame_start();
    freq0 = req_n;
    fpix0 = pix_n;
  endtask

  task automatic run_frame(input bit bp, input bit stall, input bit relaunch, input bit clr_end);
    bit got;
    got   = 0;
    bp_en = bp;
    frame_start();
    if (stall) bus_rrdy = 1'b0;
    cpb_wr(5'd4, 32'd1);
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        chk("stall_rval", {31'd0, bus_rval}, 32'd1);
        chk("stall_raddr", bus_raddr, 32'h1000);
        @(posedge clk);
        #1;
      end
      bus_rrdy = 1'b1;
    end
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (relaunch && i == 10) begin
        cpb_w = 1'b1; cpb_a = 5'd4; cpb_d = 32'd1;
      end
      if (relaunch && i == 11) cpb_w = 1'b0;
      if (dst_val && dst_rdy && dst_eof) begin
        got = 1;
        if (clr_end) begin
          cpb_w = 1'b1; cpb_a = 5'd2; cpb_d = 32'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    cpb_w = 1'b0;
    bp_en = 0;
    chk("frame_end_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_req_count"}, 32'(req_n - freq0), 32'd2);
    chk({tag, "_req_addr_err"}, 32'(req_bad), 32'd0);
    chk({tag, "_pix_count"}, 32'(pix_n - fpix0), 32'd128);
    chk({tag, "_pix_err"}, 32'(pix_bad), 32'd0);
    chk({tag, "_sof_eof_err"}, 32'(mark_bad), 32'd0);
    chk({tag, "_stable_err"}, 32'(stab_bad), 32'd0);
    chk({tag, "_hold_err"}, 32'(hold_bad), 32'd0);
    chk({tag, "_outst_err"}, 32'(out_bad), 32'd0);
  endtask

  initial begin
    logic [31:0] q;
    rst_n    = 1'b0;
    cpb_w    = 1'b0;
    cpb_a    = '0;
    cpb_d    = '0;
    bus_rrdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {27'd0, dst_val, dst_sof, dst_eof, bus_rval, irq}, 32'd0);
    chk("rst_raddr", bus_raddr, 32'd0);
    chk("rst_rlen_d", {20'd0, bus_rlen, dst_d}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cpb_rd(5'd2, q); chk("rst_sr", q, 32'd0);

    // Registers
    cpb_rd(5'd0, q); chk("idr", q, 32'hCE7);
    cpb_wr(5'd3, 32'h1000);
    cpb_rd(5'd3, q); chk("sa_readback", q, 32'h1000);
    cpb_wr(5'd7, 32'hFFFF_FFFF);
    cpb_rd(5'd7, q); chk("unmapped", q, 32'd0);
    cpb_wr(5'd1, 32'd1);
    cpb_rd(5'd1, q); chk("cr_readback", q, 32'd1);

    // Basic frame
    run_frame(0, 0, 0, 0);
    frame_checks("basic");
    cpb_rd(5'd2, q); chk("basic_sr_done", q, 32'd1);
    chk("basic_irq", {31'd0, irq}, 32'd1);

    // Clear done
    cpb_wr(5'd2, 32'd1);
    cpb_rd(5'd2, q); chk("sr_clear", q, 32'd0);
    chk("irq_clear", {31'd0, irq}, 32'd0);

    // Backpressure
    run_frame(1, 0, 0, 0);
    frame_checks("bp");
    cpb_wr(5'd2, 32'd1);

    // Request stall
    run_frame(0, 1, 0, 0);
    frame_checks("stall");
    cpb_wr(5'd2, 32'd1);

    // Launch while busy is ignored
    run_frame(0, 0, 1, 0);
    frame_checks("relaunch");
    repeat (30) @(posedge clk);
    #1;
    chk("relaunch_no_extra_req", 32'(req_n - freq0), 32'd2);
    chk("relaunch_no_extra_pix", 32'(pix_n - fpix0), 32'd128);
    cpb_rd(5'd2, q); chk("relaunch_sr_idle_done", q, 32'd1);
    cpb_wr(5'd2, 32'd1);

    // Done-set coincident with SR clear: set wins
    run_frame(0, 0, 0, 1);
    frame_checks("coincide");
    cpb_rd(5'd2, q); chk("coincide_done_kept", q, 32'd1);
    chk("coincide_irq", {31'd0, irq}, 32'd1);

    // Reset mid-frame, then relaunch
    frame_start();
    cpb_wr(5'd4, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    cpb_rd(5'd2, q); chk("pre_rst_busy", q, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {27'd0, dst_val, dst_sof, dst_eof, bus_rval, irq}, 32'd0);
    chk("mid_rst_raddr", bus_raddr, 32'd0);
    chk("mid_rst_rlen_d", {20'd0, bus_rlen, dst_d}, 32'd0);
    cpb_rd(5'd2, q); chk("mid_rst_sr", q, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    cpb_wr(5'd3, 32'h1000);
    cpb_wr(5'd1, 32'd1);
    run_frame(0, 0, 0, 0);
    frame_checks("post_rst");
    cpb_rd(5'd2, q); chk("post_rst_sr", q, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
